// File: rtl/datapath_controller.sv
// datapath_controller: PC/IR owner, instruction fetch/decode and multicycle control FSM for the 16-bit datapath
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   IM_data / IM_addr     instruction memory read data (1-cycle latency) / address (= PC)
//   D_addr, D_wr          data memory address and write enable
//   RF_W_addr/A/B, RF_W_en, RF_s   register file addresses, write enable, write-mux select (1 = memory)
//   ALU_sel               ALU opcode
//   PC, IR, state, halted debug/visibility of internal state
module datapath_controller #(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4,
    parameter int PC_W     = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    IM_data,
    output logic [PC_W-1:0]     IM_addr,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [3:0]          ALU_sel,
    output logic [PC_W-1:0]     PC,
    output logic [WIDTH-1:0]    IR,
    output logic [3:0]          state,
    output logic                halted
);
    typedef enum logic [3:0] {
        INIT   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        STORE  = 4'd3,
        LOAD_A = 4'd4,
        LOAD_B = 4'd5,
        ALU    = 4'd6,
        HALT   = 4'd7
    } state_t;

    state_t     cur, nxt;
    logic [3:0] op, im_op;
    logic       is_st, is_ld, is_alu;

    assign op     = IR[15:12];
    assign im_op  = IM_data[15:12];
    assign is_st  = op == 4'h1;
    assign is_ld  = op == 4'h2;
    assign is_alu = op[3:2] != 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= INIT;
            PC  <= '0;
            IR  <= '0;
        end else begin
            cur <= nxt;
            if (cur == INIT) PC <= '0;
            if (cur == DECODE) begin
                IR <= IM_data;
                PC <= PC + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            INIT:    nxt = FETCH;
            FETCH:   nxt = DECODE;
            DECODE:  nxt = im_op == 4'h0 ? FETCH  :
                           im_op == 4'h1 ? STORE  :
                           im_op == 4'h2 ? LOAD_A :
                           im_op == 4'h3 ? HALT   : ALU;
            STORE:   nxt = FETCH;
            LOAD_A:  nxt = LOAD_B;
            LOAD_B:  nxt = FETCH;
            ALU:     nxt = FETCH;
            HALT:    nxt = HALT;
            default: nxt = INIT;
        endcase
    end

    assign IM_addr   = PC;
    assign state     = cur;
    assign D_addr    = (is_st || is_ld) ? IR[11:4] : '0;
    assign RF_A_addr = is_st ? IR[3:0] : is_alu ? IR[11:8] : '0;
    assign RF_B_addr = is_alu ? IR[7:4] : '0;
    assign RF_W_addr = (is_ld || is_alu) ? IR[3:0] : '0;
    assign ALU_sel   = is_alu ? op : 4'h0;

    // Enables are also masked by reset so nothing fires while an aborted instruction is still in the state register.
    assign D_wr    = !reset && cur == STORE;
    assign RF_W_en = !reset && (cur == LOAD_B || cur == ALU);
    assign RF_s    = !reset && (cur == LOAD_A || cur == LOAD_B);
    assign halted  = !reset && cur == HALT;
endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: scoreboard bench for datapath_controller
module tb_datapath_controller;
    logic        clk = 0, reset = 1;
    logic [15:0] IM_data = '0;
    logic [6:0]  IM_addr, PC;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel, state;
    logic        D_wr, RF_s, RF_W_en, halted;
    logic [15:0] IR;
    logic [15:0] rom [128];

    int tests = 0, fails = 0;

    typedef struct {
        bit         st;
        bit         alu;
        logic [7:0] d;
        logic [3:0] a, b, w, sel;
        logic       s;
    } exp_t;
    exp_t sb[$];

    datapath_controller dut (
        .clk(clk), .reset(reset), .IM_data(IM_data), .IM_addr(IM_addr),
        .D_addr(D_addr), .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
        .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .ALU_sel(ALU_sel),
        .PC(PC), .IR(IR), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) IM_data <= rom[IM_addr];

    always @(negedge clk) begin
        if (D_wr === 1'b1 && RF_W_en === 1'b1) begin
            tests++; fails++;
            $display("FAIL both_enables: D_wr=%b RF_W_en=%b required not both high", D_wr, RF_W_en);
        end
        if (D_wr === 1'b1 || RF_W_en === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: D_wr=%b RF_W_en=%b with nothing expected", D_wr, RF_W_en);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.st) begin
                    if (D_wr !== 1'b1 || D_addr !== e.d || RF_A_addr !== e.a) begin
                        fails++;
                        $display("FAIL store_pulse: D_wr=%b D_addr=%h A=%h required 1 %h %h", D_wr, D_addr, RF_A_addr, e.d, e.a);
                    end
                end else if (e.alu) begin
                    if (RF_W_en !== 1'b1 || RF_s !== 1'b0 || ALU_sel !== e.sel || RF_A_addr !== e.a ||
                        RF_B_addr !== e.b || RF_W_addr !== e.w) begin
                        fails++;
                        $display("FAIL alu_pulse: en=%b s=%b sel=%h A=%h B=%h W=%h required 1 0 %h %h %h %h",
                                 RF_W_en, RF_s, ALU_sel, RF_A_addr, RF_B_addr, RF_W_addr, e.sel, e.a, e.b, e.w);
                    end
                end else begin
                    if (RF_W_en !== 1'b1 || RF_s !== 1'b1 || D_addr !== e.d || RF_W_addr !== e.w) begin
                        fails++;
                        $display("FAIL load_pulse: en=%b s=%b D_addr=%h W=%h required 1 1 %h %h",
                                 RF_W_en, RF_s, D_addr, RF_W_addr, e.d, e.w);
                    end
                end
            end
        end
    end

    function automatic void push_store(logic [7:0] d, logic [3:0] a);
        exp_t e = '{st: 1, alu: 0, d: d, a: a, b: 0, w: 0, sel: 0, s: 0};
        sb.push_back(e);
    endfunction

    function automatic void push_load(logic [7:0] d, logic [3:0] w);
        exp_t e = '{st: 0, alu: 0, d: d, a: 0, b: 0, w: w, sel: 0, s: 1};
        sb.push_back(e);
    endfunction

    function automatic void push_alu(logic [3:0] sel, logic [3:0] a, logic [3:0] b, logic [3:0] w);
        exp_t e = '{st: 0, alu: 1, d: 0, a: a, b: b, w: w, sel: sel, s: 0};
        sb.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1;
        step(2);
        tests++;
        if (state !== 4'd0 || PC !== 7'd0 || IR !== 16'h0 || halted !== 1'b0 ||
            D_wr !== 1'b0 || RF_W_en !== 1'b0 || RF_s !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: state=%0d PC=%0d IR=%h halted=%b D_wr=%b en=%b s=%b required 0 0 0000 0 0 0 0",
                     state, PC, IR, halted, D_wr, RF_W_en, RF_s);
        end
        reset = 0;
    endtask

    task automatic check_sb_empty(string name);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_scoreboard: %0d expected writes not seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
    endtask

    task automatic test_noop();
        clear_rom();
        do_reset();
        step(1);
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (state !== 4'd1 || PC !== 7'(k)) begin
                fails++;
                $display("FAIL noop_fetch_pc: state=%0d PC=%0d required 1 %0d", state, PC, k);
            end
            step(2);
        end
        check_sb_empty("noop");
    endtask

    task automatic test_program();
        clear_rom();
        rom[0] = 16'h1A53;
        rom[1] = 16'h2107;
        rom[2] = 16'h5123;
        rom[3] = 16'h0000;
        rom[4] = 16'h3000;
        push_store(8'hA5, 4'h3);
        push_load(8'h10, 4'h7);
        push_alu(4'h5, 4'h1, 4'h2, 4'h3);
        do_reset();
        step(3);
        tests++;
        if (state !== 4'd3 || D_wr !== 1'b1 || RF_W_en !== 1'b0) begin
            fails++;
            $display("FAIL store_cycle: state=%0d D_wr=%b en=%b required 3 1 0", state, D_wr, RF_W_en);
        end
        step(1);
        tests++;
        if (state !== 4'd1 || PC !== 7'd1 || D_wr !== 1'b0) begin
            fails++;
            $display("FAIL store_done: state=%0d PC=%0d D_wr=%b required 1 1 0", state, PC, D_wr);
        end
        step(2);
        tests++;
        if (state !== 4'd4 || RF_s !== 1'b1 || RF_W_en !== 1'b0 || D_addr !== 8'h10) begin
            fails++;
            $display("FAIL load_a: state=%0d s=%b en=%b D_addr=%h required 4 1 0 10", state, RF_s, RF_W_en, D_addr);
        end
        step(1);
        tests++;
        if (state !== 4'd5 || RF_s !== 1'b1 || RF_W_en !== 1'b1) begin
            fails++;
            $display("FAIL load_b: state=%0d s=%b en=%b required 5 1 1", state, RF_s, RF_W_en);
        end
        step(1);
        tests++;
        if (state !== 4'd1 || PC !== 7'd2 || RF_s !== 1'b0 || RF_W_en !== 1'b0) begin
            fails++;
            $display("FAIL load_done: state=%0d PC=%0d s=%b en=%b required 1 2 0 0", state, PC, RF_s, RF_W_en);
        end
        step(2);
        tests++;
        if (state !== 4'd6 || RF_W_en !== 1'b1 || RF_s !== 1'b0 || ALU_sel !== 4'h5) begin
            fails++;
            $display("FAIL alu_cycle: state=%0d en=%b s=%b sel=%h required 6 1 0 5", state, RF_W_en, RF_s, ALU_sel);
        end
        step(1);
        tests++;
        if (RF_W_en !== 1'b0 || PC !== 7'd3) begin
            fails++;
            $display("FAIL alu_done: en=%b PC=%0d required 0 3", RF_W_en, PC);
        end
        step(5);
        for (int k = 0; k < 22; k++) begin
            tests++;
            if (state !== 4'd7 || halted !== 1'b1 || PC !== 7'd5 || D_wr !== 1'b0 || RF_W_en !== 1'b0 || RF_s !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold: state=%0d halted=%b PC=%0d D_wr=%b en=%b s=%b required 7 1 5 0 0 0",
                         state, halted, PC, D_wr, RF_W_en, RF_s);
            end
            step(1);
        end
        check_sb_empty("program");
        reset = 1;
        step(1);
        tests++;
        if (state !== 4'd0 || PC !== 7'd0 || halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: state=%0d PC=%0d halted=%b required 0 0 0", state, PC, halted);
        end
        reset = 0;
    endtask

    task automatic test_pc_wrap();
        clear_rom();
        do_reset();
        step(1 + 254);
        tests++;
        if (state !== 4'd1 || PC !== 7'd127) begin
            fails++;
            $display("FAIL pc_preset: state=%0d PC=%0d required 1 127", state, PC);
        end
        step(2);
        tests++;
        if (state !== 4'd1 || PC !== 7'd0) begin
            fails++;
            $display("FAIL pc_wrap: state=%0d PC=%0d required 1 0", state, PC);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_rom();
        rom[0] = 16'h2107;
        do_reset();
        step(3);
        tests++;
        if (state !== 4'd4) begin
            fails++;
            $display("FAIL abort_in_load_a: state=%0d required 4", state);
        end
        reset = 1;
        step(1);
        tests++;
        if (state !== 4'd0 || PC !== 7'd0 || RF_W_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: state=%0d PC=%0d en=%b required 0 0 0", state, PC, RF_W_en);
        end
        reset = 0;
        step(1);
        tests++;
        if (state !== 4'd1 || RF_W_en !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: state=%0d en=%b required 1 0", state, RF_W_en);
        end
        reset = 1;
        step(1);
        check_sb_empty("abort");
    endtask

    task automatic test_back_to_back();
        clear_rom();
        rom[0] = 16'h1A53;
        rom[1] = 16'h1FF0;
        rom[2] = 16'hF456;
        rom[3] = 16'h2C39;
        rom[4] = 16'h3000;
        push_store(8'hA5, 4'h3);
        push_store(8'hFF, 4'h0);
        push_alu(4'hF, 4'h4, 4'h5, 4'h6);
        push_load(8'hC3, 4'h9);
        do_reset();
        step(1 + 3 + 3 + 3 + 4 + 3);
        tests++;
        if (halted !== 1'b1 || PC !== 7'd5) begin
            fails++;
            $display("FAIL b2b_halt: halted=%b PC=%0d required 1 5", halted, PC);
        end
        check_sb_empty("b2b");
    endtask

    initial begin
        test_reset();
        test_noop();
        test_program();
        test_pc_wrap();
        test_reset_mid_load();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Upstream control stage for the 16-bit datapath: owns PC and instruction register (IR), fetches from an external instruction memory, and decodes each instruction.
- Sequences a multicycle FSM that drives every datapath control input: D_addr, RF_W_addr/RF_A_addr/RF_B_addr, D_wr, RF_s, RF_W_en, ALU_sel.
- Sits between the instruction ROM and the datapath.

Parameters:
- WIDTH, 16, instruction/data word width.
- D_ADDR_W, 8, data memory address width.
- R_ADDR_W, 4, register file address width.
- PC_W, 7, program counter / instruction memory address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- IM_data  input  WIDTH  instruction memory read data; valid 1 cycle after IM_addr is presented.
- IM_addr  output  PC_W  instruction memory address, equals PC.
- D_addr  output  D_ADDR_W  data memory address.
- RF_W_addr  output  R_ADDR_W  register file write address.
- RF_A_addr  output  R_ADDR_W  register file port A read address.
- RF_B_addr  output  R_ADDR_W  register file port B read address.
- D_wr  output  1  data memory write enable (writes port A value).
- RF_s  output  1  RF write mux select: 1 = memory data, 0 = ALU result.
- RF_W_en  output  1  register file write enable.
- ALU_sel  output  4  ALU opcode.
- PC  output  PC_W  current program counter.
- IR  output  WIDTH  current instruction register.
- state  output  4  encoded FSM state, for debug.
- halted  output  1  high while in HALT.

Behaviour:
- Instruction format: opcode = IR[15:12].
  - 0x0 NOOP.
  - 0x1 STORE: D_addr = IR[11:4], RF_A_addr = IR[3:0].
  - 0x2 LOAD: D_addr = IR[11:4], RF_W_addr = IR[3:0].
  - 0x3 HALT.
  - 0x4-0xF ALU op: RF_A_addr = IR[11:8], RF_B_addr = IR[7:4], RF_W_addr = IR[3:0], ALU_sel = IR[15:12].
- Field outputs (D_addr, RF_*_addr, ALU_sel) are decoded combinationally from IR at all times. Only the enables are state-gated.
- Reset (synchronous): next edge forces state = INIT, PC = 0, IR = 0. D_wr, RF_W_en, RF_s and halted are 0 during and after reset.
- Reset asserted mid-instruction aborts it. No write enable is asserted in the cycle after reset is sampled.
- States and transitions:
  - INIT: PC = 0 -> FETCH.
  - FETCH: IM_addr = PC held -> DECODE.
  - DECODE: IR <= IM_data; PC <= PC+1. Next state chosen from IM_data[15:12]: NOOP -> FETCH, STORE -> STORE, LOAD -> LOAD_A, HALT -> HALT, else ALU.
  - STORE: D_wr = 1 for exactly 1 cycle -> FETCH.
  - LOAD_A: RF_s = 1, D_addr driven, no write -> LOAD_B.
  - LOAD_B: RF_s = 1, RF_W_en = 1 for 1 cycle -> FETCH.
  - ALU: RF_s = 0, RF_W_en = 1 for 1 cycle -> FETCH.
  - HALT: all enables 0, halted = 1, PC frozen. Remains until reset.
- Cycles per instruction: NOOP 2, STORE 3, ALU 3, LOAD 4.
- D_wr and RF_W_en are never high together. Each is a single-cycle pulse per instruction.
- PC is unsigned, increments modulo 2^PC_W. PC = 2^PC_W-1 wraps to 0 with no flag.
- HALT increments PC in DECODE like any instruction. PC then reads address of HALT + 1.
- RF_s holds 0 in every state other than LOAD_A and LOAD_B.

Test Plan:
- Reset then NOOP stream (IM_data = 0x0000) -> PC 0,1,2,... one increment per 2 cycles; D_wr and RF_W_en never asserted.
- STORE 0x1A53 -> D_addr = 0xA5, RF_A_addr = 3, D_wr high for exactly 1 cycle in the 3rd cycle after FETCH entry; RF_W_en stays 0.
- LOAD 0x2107 -> D_addr = 0x10, RF_W_addr = 7, RF_s = 1 for 2 cycles, RF_W_en pulse only in LOAD_B; next FETCH at PC+1.
- ALU op 0x5123 -> ALU_sel = 5, RF_A_addr = 1, RF_B_addr = 2, RF_W_addr = 3, RF_s = 0, RF_W_en 1-cycle pulse.
- HALT 0x3000 at PC = 4 -> halted = 1, PC stays 5 for 20+ cycles, no enables. Then reset -> PC = 0, state = INIT, halted = 0.
- PC preset to 127 via NOOP program -> after DECODE PC = 0. Reset asserted during LOAD_A -> no RF_W_en pulse, state = INIT on the next edge.
